// File: rtl/fetch_stage.sv
// RV32I fetch stage + IF/ID register: zero-wait memory delivers PC_F's instruction on IF/ID next cycle.
// Backpressure: imem_ready low holds imem_addr; stall_D parks a ready instruction in HOLD with no request.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        async_reset,
  input  logic        stall_D,
  input  logic        flush_D,
  input  logic        pc_src_E,
  input  logic [31:0] target_PC_E,
  input  logic        predict_taken_D,
  input  logic [31:0] predicted_PC_address_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC_plus_4_D,
  output logic        valid_D,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {S_FETCH, S_DISCARD, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_vld_q, ifid_vld_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_f_plus4;
  logic        load;
  logic        bubble;
  logic [31:0] load_instr;

  // Execute-stage redirect outranks the decode prediction.
  assign redirect   = pc_src_E | predict_taken_D;
  assign target     = (pc_src_E ? target_PC_E : predicted_PC_address_D) & ~32'h3;
  assign pc_f_plus4 = pc_f_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_f_d        = pc_f_q;
    redirect_pc_d = redirect_pc_q;
    hold_instr_d  = hold_instr_q;
    load          = 1'b0;
    bubble        = 1'b0;
    load_instr    = imem_rdata;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          if (redirect) begin
            pc_f_d = target;
            bubble = 1'b1;
          end else if (stall_D || flush_D) begin
            // Park the accepted word so a flush without redirect does not lose it.
            hold_instr_d = imem_rdata;
            state_d      = S_HOLD;
          end else begin
            load   = 1'b1;
            pc_f_d = pc_f_plus4;
          end
        end else begin
          bubble = 1'b1;
          if (redirect) begin
            redirect_pc_d = target;
            state_d       = S_DISCARD;
          end
        end
      end
      S_DISCARD: begin
        bubble = 1'b1;
        if (redirect) redirect_pc_d = target;
        if (imem_ready) begin
          pc_f_d  = redirect ? target : redirect_pc_q;
          state_d = S_FETCH;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_f_d  = target;
          bubble  = 1'b1;
          state_d = S_FETCH;
        end else if (!stall_D && !flush_D) begin
          load       = 1'b1;
          load_instr = hold_instr_q;
          pc_f_d     = pc_f_plus4;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_vld_d   = ifid_vld_q;
    if (flush_D || (!stall_D && !load && bubble)) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = 32'd0;
      ifid_pc4_d   = 32'd0;
      ifid_vld_d   = 1'b0;
    end else if (!stall_D && load) begin
      ifid_instr_d = load_instr;
      ifid_pc_d    = pc_f_q;
      ifid_pc4_d   = pc_f_plus4;
      ifid_vld_d   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      state_q       <= S_FETCH;
      pc_f_q        <= RESET_PC;
      redirect_pc_q <= 32'd0;
      hold_instr_q  <= NOP_INSTR;
      ifid_instr_q  <= NOP_INSTR;
      ifid_pc_q     <= 32'd0;
      ifid_pc4_q    <= 32'd0;
      ifid_vld_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_f_q        <= pc_f_d;
      redirect_pc_q <= redirect_pc_d;
      hold_instr_q  <= hold_instr_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_pc4_q    <= ifid_pc4_d;
      ifid_vld_q    <= ifid_vld_d;
    end
  end

  assign imem_req      = async_reset && (state_q != S_HOLD);
  assign imem_addr     = pc_f_q;
  assign fetch_busy    = async_reset && (state_q != S_HOLD) && !imem_ready;
  assign instruction_D = ifid_instr_q;
  assign PC_D          = ifid_pc_q;
  assign PC_plus_4_D   = ifid_pc4_q;
  assign valid_D       = ifid_vld_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one vector row per clock cycle, then reset and PC-wrap sequences.
module tb_fetch_stage;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] MEM_KEY = 32'h5A5A_0000;

  logic        clock = 1'b0;
  logic        async_reset;
  logic        stall_D, flush_D, pc_src_E, predict_taken_D, imem_ready;
  logic [31:0] target_PC_E, predicted_PC_address_D;
  logic        imem_req, valid_D, fetch_busy;
  logic [31:0] imem_addr, imem_rdata, instruction_D, PC_D, PC_plus_4_D;

  always #5 clock = ~clock;

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clock(clock), .async_reset(async_reset),
    .stall_D(stall_D), .flush_D(flush_D),
    .pc_src_E(pc_src_E), .target_PC_E(target_PC_E),
    .predict_taken_D(predict_taken_D), .predicted_PC_address_D(predicted_PC_address_D),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instruction_D(instruction_D), .PC_D(PC_D), .PC_plus_4_D(PC_plus_4_D),
    .valid_D(valid_D), .fetch_busy(fetch_busy)
  );

  // Memory contents are a fixed function of the address.
  assign imem_rdata = imem_addr ^ MEM_KEY;

  typedef struct {
    logic        rdy, stall, flush, src;
    logic [31:0] tgt;
    logic        pred;
    logic [31:0] ppc;
    logic        req;
    logic [31:0] addr;
    logic        busy, vld;
    logic [31:0] pcd;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int passed = 0;

  function automatic void add(input logic rdy, input logic stall, input logic flush,
                              input logic src, input logic [31:0] tgt, input logic pred,
                              input logic [31:0] ppc, input logic req, input logic [31:0] addr,
                              input logic busy, input logic vld, input logic [31:0] pcd);
    vec_t v;
    v = '{rdy, stall, flush, src, tgt, pred, ppc, req, addr, busy, vld, pcd};
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_ifid(input string tag, input logic vld, input logic [31:0] pcd);
    check({tag, " valid_D"}, {31'd0, valid_D}, {31'd0, vld});
    check({tag, " PC_D"}, PC_D, pcd);
    check({tag, " PC_plus_4_D"}, PC_plus_4_D, vld ? pcd + 32'd4 : 32'd0);
    check({tag, " instruction_D"}, instruction_D, vld ? (pcd ^ MEM_KEY) : NOP);
  endtask

  task automatic drive(input logic rdy, input logic stall, input logic flush, input logic src,
                       input logic [31:0] tgt, input logic pred, input logic [31:0] ppc);
    imem_ready = rdy; stall_D = stall; flush_D = flush;
    pc_src_E = src; target_PC_E = tgt;
    predict_taken_D = pred; predicted_PC_address_D = ppc;
  endtask

  initial begin
    // rdy stall flush src tgt pred ppc | req addr busy vld PC_D
    add(1,0,0,0,0,0,0,            1,32'h000,0,0,32'h000);
    add(1,0,0,0,0,0,0,            1,32'h004,0,1,32'h000);
    add(1,0,0,0,0,0,0,            1,32'h008,0,1,32'h004);
    add(1,0,0,0,0,0,0,            1,32'h00C,0,1,32'h008);
    add(0,0,0,0,0,0,0,            1,32'h010,1,1,32'h00C);
    add(0,0,0,0,0,0,0,            1,32'h010,1,0,32'h000);
    add(0,0,0,0,0,0,0,            1,32'h010,1,0,32'h000);
    add(1,0,0,0,0,0,0,            1,32'h010,0,0,32'h000);
    add(1,0,0,0,0,0,0,            1,32'h014,0,1,32'h010);
    add(1,0,0,0,0,0,0,            1,32'h018,0,1,32'h014);
    add(1,0,0,0,0,0,0,            1,32'h01C,0,1,32'h018);
    add(1,1,0,0,0,0,0,            1,32'h020,0,1,32'h01C);
    add(1,1,0,0,0,0,0,            0,32'h020,0,1,32'h01C);
    add(1,0,0,0,0,0,0,            0,32'h020,0,1,32'h01C);
    add(1,0,0,0,0,0,0,            1,32'h024,0,1,32'h020);
    add(1,0,0,0,0,0,0,            1,32'h028,0,1,32'h024);
    add(1,0,0,0,0,0,0,            1,32'h02C,0,1,32'h028);
    add(0,0,0,0,0,0,0,            1,32'h030,1,1,32'h02C);
    add(0,0,0,1,32'h103,0,0,      1,32'h030,1,0,32'h000);
    add(0,0,0,0,0,0,0,            1,32'h030,1,0,32'h000);
    add(1,0,0,0,0,0,0,            1,32'h030,0,0,32'h000);
    add(1,0,0,0,0,0,0,            1,32'h100,0,0,32'h000);
    add(1,0,0,1,32'h400,1,32'h200,1,32'h104,0,1,32'h100);
    add(1,0,0,0,0,0,0,            1,32'h400,0,0,32'h000);
    add(1,0,1,0,0,0,0,            1,32'h404,0,1,32'h400);
    add(1,0,0,0,0,0,0,            0,32'h404,0,0,32'h000);
    add(1,0,0,0,0,0,0,            1,32'h408,0,1,32'h404);

    async_reset = 1'b0;
    drive(1,0,0,0,0,0,0);
    repeat (2) @(posedge clock);
    #1;
    check("reset imem_req", {31'd0, imem_req}, 32'd0);
    check_ifid("reset", 1'b0, 32'd0);
    async_reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("row%0d", i);
      drive(vecs[i].rdy, vecs[i].stall, vecs[i].flush, vecs[i].src,
            vecs[i].tgt, vecs[i].pred, vecs[i].ppc);
      @(negedge clock);
      check({tag, " imem_req"}, {31'd0, imem_req}, {31'd0, vecs[i].req});
      check({tag, " imem_addr"}, imem_addr, vecs[i].addr);
      check({tag, " fetch_busy"}, {31'd0, fetch_busy}, {31'd0, vecs[i].busy});
      check_ifid(tag, vecs[i].vld, vecs[i].pcd);
      @(posedge clock);
      #1;
    end

    // Reset asserted in the middle of a memory wait at 0x40C.
    drive(0,0,0,0,0,0,0);
    @(negedge clock);
    check("wait addr", imem_addr, 32'h40C);
    check("wait busy", {31'd0, fetch_busy}, 32'd1);
    #2 async_reset = 1'b0;
    #1;
    check("midreset imem_req", {31'd0, imem_req}, 32'd0);
    check("midreset imem_addr", imem_addr, 32'h0);
    check_ifid("midreset", 1'b0, 32'd0);
    @(posedge clock);
    #1;
    async_reset = 1'b1;
    drive(1,0,0,0,0,0,0);
    @(negedge clock);
    check("post-reset imem_req", {31'd0, imem_req}, 32'd1);
    check("post-reset addr", imem_addr, 32'h0);

    // Redirect to an unaligned top-of-memory target, then wrap past 2^32.
    @(posedge clock);
    #1;
    drive(1,0,0,1,32'hFFFF_FFFE,0,0);
    @(posedge clock);
    #1;
    drive(1,0,0,0,0,0,0);
    @(negedge clock);
    check("top addr", imem_addr, 32'hFFFF_FFFC);
    @(posedge clock);
    #1;
    check("wrap addr", imem_addr, 32'h0);
    check_ifid("wrap", 1'b1, 32'hFFFF_FFFC);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
